traffic_ctrl_multi: RTL and testbench

Parametrised multi-phase traffic-signal controller, the successor to the fixed two-direction sequencer. It serves NUM_PHASES conflicting approaches and runs each through green, yellow and all-red clearance with run-time programmable durations. It adds an optional demand-actuated mode that skips idle phases and extends green, plus a latched pedestrian-walk request. It sits under the intersection top level and drives lamp decoders directly.

---
 rtl/traffic_ctrl_multi.sv | 159 +++++++++++++++
 tb/tb_traffic_ctrl_multi.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_ctrl_multi.sv
// Multi-phase traffic-signal controller: green/yellow/all-red rotation over NUM_PHASES approaches
// with optional demand-actuated skipping/extension and a latched pedestrian walk interval.
`timescale 1ns/1ps
module traffic_ctrl_multi #(
    parameter int unsigned NUM_PHASES = 2,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned PH_W       = $clog2(NUM_PHASES)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    actuated,
    input  logic [NUM_PHASES-1:0]   req,
    input  logic                    ped_req,
    input  logic [CNT_W-1:0]        green_len,
    input  logic [CNT_W-1:0]        yellow_len,
    input  logic [CNT_W-1:0]        allred_len,
    input  logic [CNT_W-1:0]        walk_len,
    output logic [2*NUM_PHASES-1:0] light,
    output logic                    walk,
    output logic                    ped_wait,
    output logic [PH_W-1:0]         phase,
    output logic [1:0]              state_o
);

    typedef enum logic [1:0] {
        StGreen  = 2'd0,
        StYellow = 2'd1,
        StAllRed = 2'd2,
        StWalk   = 2'd3
    } state_e;

    state_e             r_state;
    logic [PH_W-1:0]    r_phase;
    logic [PH_W-1:0]    r_next_phase;
    logic [CNT_W-1:0]   r_timer;
    logic               r_ped_pending;

    state_e             w_state_nxt;
    logic [PH_W-1:0]    w_phase_nxt;
    logic [PH_W-1:0]    w_next_phase_nxt;
    logic [CNT_W-1:0]   w_timer_nxt;
    logic               w_ped_nxt;

    logic [NUM_PHASES-1:0] w_other_req;
    logic [PH_W-1:0]       w_inc_phase;
    logic [PH_W-1:0]       w_rr_phase;
    logic [PH_W-1:0]       w_next_phase_sel;
    logic                  w_found;

    // A programmed length of 0 behaves like 1, so the timer never wraps.
    function automatic logic [CNT_W-1:0] f_load(input logic [CNT_W-1:0] len);
        return (len == '0) ? '0 : len - 1'b1;
    endfunction

    assign w_inc_phase = (r_phase == PH_W'(NUM_PHASES - 1)) ? '0 : r_phase + 1'b1;

    // Round-robin search starting just after the current phase; current phase is checked last.
    always_comb begin
        w_other_req          = req;
        w_other_req[r_phase] = 1'b0;
        w_rr_phase           = w_inc_phase;
        w_found              = 1'b0;
        for (int unsigned k = 1; k <= NUM_PHASES; k++) begin
            int unsigned idx;
            idx = (int'(r_phase) + k) % NUM_PHASES;
            if (!w_found && req[idx[PH_W-1:0]]) begin
                w_found    = 1'b1;
                w_rr_phase = idx[PH_W-1:0];
            end
        end
        w_next_phase_sel = actuated ? w_rr_phase : w_inc_phase;
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_phase_nxt      = r_phase;
        w_next_phase_nxt = r_next_phase;
        w_timer_nxt      = r_timer;
        w_ped_nxt        = r_ped_pending | ped_req;
        if (en) begin
            if (r_timer != '0) begin
                w_timer_nxt = r_timer - 1'b1;
            end else begin
                unique case (r_state)
                    StGreen: begin
                        if (actuated && (w_other_req == '0) && !r_ped_pending) begin
                            w_timer_nxt = f_load(green_len);
                        end else begin
                            w_state_nxt = StYellow;
                            w_timer_nxt = f_load(yellow_len);
                        end
                    end
                    StYellow: begin
                        w_state_nxt      = StAllRed;
                        w_timer_nxt      = f_load(allred_len);
                        w_next_phase_nxt = w_next_phase_sel;
                    end
                    StAllRed: begin
                        if (r_ped_pending) begin
                            // A push arriving on the walk-entry cycle is served by this walk.
                            w_state_nxt = StWalk;
                            w_timer_nxt = f_load(walk_len);
                            w_ped_nxt   = 1'b0;
                        end else begin
                            w_state_nxt = StGreen;
                            w_phase_nxt = r_next_phase;
                            w_timer_nxt = f_load(green_len);
                        end
                    end
                    StWalk: begin
                        w_state_nxt = StGreen;
                        w_phase_nxt = r_next_phase;
                        w_timer_nxt = f_load(green_len);
                    end
                    default: begin
                        w_state_nxt = StAllRed;
                        w_timer_nxt = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= StAllRed;
            r_phase       <= '0;
            r_next_phase  <= '0;
            r_timer       <= '0;
            r_ped_pending <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_phase       <= w_phase_nxt;
            r_next_phase  <= w_next_phase_nxt;
            r_timer       <= w_timer_nxt;
            r_ped_pending <= w_ped_nxt;
        end
    end

    always_comb begin
        light = '0;
        for (int p = 0; p < int'(NUM_PHASES); p++) begin
            if (PH_W'(p) == r_phase) begin
                if (r_state == StGreen) begin
                    light[2*p +: 2] = 2'b10;
                end else if (r_state == StYellow) begin
                    light[2*p +: 2] = 2'b01;
                end
            end
        end
    end

    assign walk     = (r_state == StWalk);
    assign ped_wait = r_ped_pending;
    assign phase    = r_phase;
    assign state_o  = r_state;

endmodule

// File: tb/tb_traffic_ctrl_multi.sv
// Self-checking bench for traffic_ctrl_multi: directed scenarios plus randomized traffic,
// all checked every cycle against a dwell-count behavioural model.
`timescale 1ns/1ps
module tb_traffic_ctrl_multi;

    localparam int N  = 4;
    localparam int CW = 16;
    localparam int PW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0;
    logic          actuated = 1'b0;
    logic [N-1:0]  req = '0;
    logic          ped_req = 1'b0;
    logic [CW-1:0] green_len = '0;
    logic [CW-1:0] yellow_len = '0;
    logic [CW-1:0] allred_len = '0;
    logic [CW-1:0] walk_len = '0;
    logic [2*N-1:0] light;
    logic          walk;
    logic          ped_wait;
    logic [PW-1:0] phase;
    logic [1:0]    state_o;

    traffic_ctrl_multi #(.NUM_PHASES(N), .CNT_W(CW), .PH_W(PW)) dut (
        .clk(clk), .rst(rst), .en(en), .actuated(actuated), .req(req), .ped_req(ped_req),
        .green_len(green_len), .yellow_len(yellow_len), .allred_len(allred_len),
        .walk_len(walk_len), .light(light), .walk(walk), .ped_wait(ped_wait),
        .phase(phase), .state_o(state_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: mode 0=green 1=yellow 2=allred 3=walk; m_rem = enabled cycles left in this mode.
    int m_mode, m_ph, m_np, m_rem;
    bit m_ped;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    function automatic int dwell(input logic [CW-1:0] l);
        return (l == 0) ? 1 : int'(l);
    endfunction

    function automatic int pick_next();
        if (actuated) begin
            for (int k = 1; k <= N; k++) begin
                if (req[(m_ph + k) % N]) return (m_ph + k) % N;
            end
        end
        return (m_ph + 1) % N;
    endfunction

    task automatic model_reset();
        m_mode = 2; m_ph = 0; m_np = 0; m_rem = 1; m_ped = 0;
    endtask

    task automatic model_step();
        bit ped_old;
        bit walk_start;
        logic [N-1:0] others;
        ped_old = m_ped;
        walk_start = 0;
        if (en) begin
            if (m_rem > 1) begin
                m_rem--;
            end else begin
                case (m_mode)
                    0: begin
                        others = req;
                        others[m_ph] = 1'b0;
                        if (actuated && others == 0 && !ped_old) m_rem = dwell(green_len);
                        else begin m_mode = 1; m_rem = dwell(yellow_len); end
                    end
                    1: begin m_np = pick_next(); m_mode = 2; m_rem = dwell(allred_len); end
                    2: begin
                        if (ped_old) begin m_mode = 3; m_rem = dwell(walk_len); walk_start = 1; end
                        else begin m_mode = 0; m_ph = m_np; m_rem = dwell(green_len); end
                    end
                    default: begin m_mode = 0; m_ph = m_np; m_rem = dwell(green_len); end
                endcase
            end
        end
        m_ped = walk_start ? 1'b0 : (ped_old | ped_req);
    endtask

    task automatic compare_all();
        logic [2*N-1:0] el;
        el = '0;
        if (m_mode == 0) el[2*m_ph +: 2] = 2'b10;
        else if (m_mode == 1) el[2*m_ph +: 2] = 2'b01;
        check("light", 32'(light), 32'(el));
        check("walk", 32'(walk), (m_mode == 3) ? 32'd1 : 32'd0);
        check("ped_wait", 32'(ped_wait), 32'(m_ped));
        check("phase", 32'(phase), 32'(m_ph));
        check("state_o", 32'(state_o), 32'(m_mode));
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else model_step();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #1;
        check("rst_state", 32'(state_o), 32'd2);
        check("rst_light", 32'(light), 32'd0);
        compare_all();
        tick();
        rst = 1'b0;
    endtask

    task automatic set_lens(input int g, input int y, input int r, input int w);
        green_len = CW'(g); yellow_len = CW'(y); allred_len = CW'(r); walk_len = CW'(w);
    endtask

    initial begin
        #2;
        // Fixed rotation, G=5 Y=2 R=1: period 32 cycles for 4 phases.
        set_lens(5, 2, 1, 4); actuated = 0; en = 1; req = '0;
        do_reset();
        for (int t = 1; t <= 33; t++) begin
            tick();
            case (t)
                1:  check("s1_g0", 32'(light), 32'h02);
                6:  check("s1_y0", 32'(light), 32'h01);
                8:  check("s1_r0", 32'(state_o), 32'd2);
                9:  check("s1_g1", 32'(light), 32'h08);
                17: check("s1_g2", 32'(light), 32'h20);
                25: check("s1_g3", 32'(light), 32'h80);
                33: check("s1_wrap", 32'(light), 32'h02);
                default: ;
            endcase
        end

        // Actuated: only req[2], skip phases 1 and 3, then extend phase 2.
        set_lens(3, 2, 1, 4); actuated = 1; req = 4'b0100;
        do_reset();
        for (int t = 1; t <= 27; t++) begin
            tick();
            if (t == 4) check("s2_y0", 32'(state_o), 32'd1);
            if (t == 7) begin
                check("s2_g2", 32'(light), 32'h20);
                req = '0;
            end
            if (t > 7) check("s2_ext", {30'd0, state_o} | (32'(phase) << 4), 32'h20);
        end

        // Pedestrian request during phase 1 green.
        set_lens(5, 2, 1, 4); actuated = 0; req = '0;
        do_reset();
        for (int t = 1; t <= 21; t++) begin
            ped_req = (t == 10);
            tick();
            if (t == 10) check("s3_wait", 32'(ped_wait), 32'd1);
            if (t == 16) check("s3_wait2", 32'(ped_wait), 32'd1);
            if (t == 17) check("s3_walk", {30'd0, walk, ped_wait}, 32'h2);
            if (t == 20) check("s3_walk4", 32'(state_o), 32'd3);
            if (t == 21) check("s3_g2", 32'(light), 32'h20);
        end
        ped_req = 0;

        // Freeze mid-yellow with one cycle left on the timer.
        do_reset();
        for (int t = 1; t <= 6; t++) tick();
        en = 0;
        for (int t = 0; t < 10; t++) begin
            tick();
            check("s4_frz", {22'd0, light, state_o}, {22'd0, 8'h01, 2'd1});
        end
        en = 1;
        tick();
        check("s4_y1", 32'(state_o), 32'd1);
        tick();
        check("s4_r", 32'(state_o), 32'd2);

        // Asynchronous reset in the middle of a walk, with another push pending.
        do_reset();
        for (int t = 1; t <= 18; t++) begin
            ped_req = (t == 10 || t == 18);
            tick();
        end
        ped_req = 0;
        check("s5_pre", {30'd0, walk, ped_wait}, 32'h3);
        rst = 1'b1;
        model_reset();
        #1;
        check("s5_rst", {21'd0, walk, ped_wait, light, state_o}, 32'd2);
        compare_all();
        tick();
        rst = 1'b0;
        tick();
        check("s5_g0", 32'(light), 32'h02);

        // Zero lengths dwell exactly one cycle each.
        set_lens(0, 0, 0, 0);
        do_reset();
        for (int t = 1; t <= 4; t++) begin
            tick();
            if (t == 2) check("s6_y", 32'(state_o), 32'd1);
            if (t == 3) check("s6_r", 32'(state_o), 32'd2);
            if (t == 4) check("s6_g1", 32'(light), 32'h08);
        end

        // Randomized traffic with occasional mid-state length changes and resets.
        set_lens(3, 2, 1, 2);
        for (int i = 0; i < 3000; i++) begin
            en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 49) == 0) actuated = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 5) == 0) req = N'($urandom_range(0, 15) & $urandom_range(0, 15));
            ped_req = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 24) == 0) green_len = CW'($urandom_range(0, 4));
            if ($urandom_range(0, 24) == 0) yellow_len = CW'($urandom_range(0, 4));
            if ($urandom_range(0, 24) == 0) allred_len = CW'($urandom_range(0, 3));
            if ($urandom_range(0, 24) == 0) walk_len = CW'($urandom_range(0, 4));
            if ($urandom_range(0, 299) == 0) begin
                rst = 1'b1;
                model_reset();
                #1;
                compare_all();
                tick();
                rst = 1'b0;
            end else begin
                tick();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
